// File: rtl/key_freq_encoder.sv
// Key event to frequency-id encoder: tracks up to two held notes and hands each
// changed set to the physics block, waiting for it to adopt one before sending the next.
module key_freq_encoder #(
  parameter int NO_FREQ = 31,
  parameter int MAX_ID  = 24,
  parameter int TIMEOUT = 2000000,
  parameter int TIMER_W = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic       key_press,
  input  logic [4:0] key_code,
  input  logic       curr_w0,
  output logic [4:0] freq_id1,
  output logic [4:0] freq_id2,
  output logic       new_f_out,
  output logic       busy
);

  localparam logic [4:0]         NO_ID      = 5'(NO_FREQ);
  localparam logic [4:0]         TOP_ID     = 5'(MAX_ID);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [4:0]         slot1_q, slot1_d;
  logic [4:0]         slot2_q, slot2_d;
  logic [4:0]         id1_q, id1_d;
  logic [4:0]         id2_q, id2_d;
  logic               sent_bank_q, sent_bank_d;
  logic               new_f_q, new_f_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic code_ok;
  logic in_slot1;
  logic in_slot2;
  logic set_changed;
  logic adopted;
  logic timed_out;

  assign code_ok     = (key_code <= TOP_ID);
  assign in_slot1    = (key_code == slot1_q);
  assign in_slot2    = (key_code == slot2_q);
  assign set_changed = ({slot1_q, slot2_q} != {id1_q, id2_q});
  assign adopted     = (curr_w0 != sent_bank_q);
  assign timed_out   = (timer_q == TIMER_LAST);

  // Held-note set; slot1 is always the older note, so eviction and release shift slot2 up.
  always_comb begin
    slot1_d = slot1_q;
    slot2_d = slot2_q;
    if (key_valid && code_ok) begin
      if (key_press) begin
        if (!in_slot1 && !in_slot2) begin
          if (slot1_q == NO_ID) begin
            slot1_d = key_code;
          end else if (slot2_q == NO_ID) begin
            slot2_d = key_code;
          end else begin
            slot1_d = slot2_q;
            slot2_d = key_code;
          end
        end
      end else if (in_slot1) begin
        slot1_d = slot2_q;
        slot2_d = NO_ID;
      end else if (in_slot2) begin
        slot2_d = NO_ID;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (set_changed) state_d = S_SEND;
      S_SEND:  state_d = S_WAIT;
      S_WAIT:  if (adopted || timed_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The ids, pulse and bank snapshot are all loaded on the edge that enters SEND.
  always_comb begin
    id1_d       = id1_q;
    id2_d       = id2_q;
    sent_bank_d = sent_bank_q;
    timer_d     = timer_q;
    new_f_d     = 1'b0;
    if (state_q == S_IDLE && set_changed) begin
      id1_d       = slot1_q;
      id2_d       = slot2_q;
      sent_bank_d = curr_w0;
      timer_d     = '0;
      new_f_d     = 1'b1;
    end else if (state_q == S_WAIT) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      slot1_q     <= NO_ID;
      slot2_q     <= NO_ID;
      id1_q       <= NO_ID;
      id2_q       <= NO_ID;
      sent_bank_q <= 1'b0;
      new_f_q     <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      slot1_q     <= slot1_d;
      slot2_q     <= slot2_d;
      id1_q       <= id1_d;
      id2_q       <= id2_d;
      sent_bank_q <= sent_bank_d;
      new_f_q     <= new_f_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    freq_id1  = id1_q;
    freq_id2  = id2_q;
    new_f_out = new_f_q;
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_key_freq_encoder.sv
// Scoreboard bench for key_freq_encoder: a note-list model predicts every pulse
// and its ids, a separate monitor consumes pulses as the DUT produces them.
module tb_key_freq_encoder;

  localparam int TIMEOUT = 40;
  localparam int NOF     = 31;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic       key_press = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       curr_w0 = 1'b0;
  logic [4:0] freq_id1, freq_id2;
  logic       new_f_out, busy;

  key_freq_encoder #(.TIMEOUT(TIMEOUT)) dut (
    .clock    (clock),
    .reset    (reset),
    .key_valid(key_valid),
    .key_press(key_press),
    .key_code (key_code),
    .curr_w0  (curr_w0),
    .freq_id1 (freq_id1),
    .freq_id2 (freq_id2),
    .new_f_out(new_f_out),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Cycle n is the interval after the n-th rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [4:0] a;
    logic [4:0] b;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: notes held, oldest first, at most two.
  int         held[$];
  logic [4:0] sent1 = 5'd31;
  logic [4:0] sent2 = 5'd31;
  int         pulse_cyc = 0;
  int         free_cyc = 0;
  bit         adopt_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void held_ids(output logic [4:0] h1, output logic [4:0] h2);
    h1 = (held.size() > 0) ? 5'(held[0]) : 5'(NOF);
    h2 = (held.size() > 1) ? 5'(held[1]) : 5'(NOF);
  endfunction

  function automatic bit settled();
    logic [4:0] h1, h2;
    held_ids(h1, h2);
    return (cyc + 1 >= free_cyc) && (h1 == sent1) && (h2 == sent2);
  endfunction

  // One cycle: check outputs, advance the model, drive inputs for the next edge.
  task automatic step(input bit kv, input bit kp, input int kc, input bit tog, input bit rst);
    int         n;
    int         idx;
    int         rel;
    bit         exp_busy;
    bit         do_tog;
    logic [4:0] h1, h2;
    @(negedge clock);
    n = cyc;
    exp_busy = (n >= pulse_cyc) && (n < free_cyc);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("freq_id1", 32'(freq_id1), 32'(sent1));
    chk("freq_id2", 32'(freq_id2), 32'(sent2));
    do_tog = 1'b0;
    if (rst) begin
      held.delete();
      sent1 = 5'd31;
      sent2 = 5'd31;
      pulse_cyc = n + 1;
      free_cyc = n + 1;
    end else begin
      if (n >= free_cyc) begin
        held_ids(h1, h2);
        if (h1 != sent1 || h2 != sent2) begin
          exp_q.push_back('{cyc: n + 1, a: h1, b: h2});
          sent1 = h1;
          sent2 = h2;
          pulse_cyc = n + 1;
          free_cyc = n + 2 + TIMEOUT;
          adopt_done = 1'b0;
        end
      end
      if (tog) begin
        if (exp_busy && !adopt_done) begin
          rel = (n > pulse_cyc) ? n + 1 : n + 2;
          if (rel < free_cyc) free_cyc = rel;
          adopt_done = 1'b1;
          do_tog = 1'b1;
        end else if (!exp_busy) begin
          do_tog = 1'b1;
        end
      end
      if (kv && kc <= 24) begin
        idx = -1;
        for (int i = 0; i < held.size(); i++) if (held[i] == kc) idx = i;
        if (kp) begin
          if (idx < 0) begin
            held.push_back(kc);
            if (held.size() > 2) void'(held.pop_front());
          end
        end else if (idx >= 0) begin
          held.delete(idx);
        end
      end
    end
    reset = rst;
    key_valid = kv && !rst;
    key_press = kp;
    key_code = 5'(kc);
    if (do_tog) curr_w0 = ~curr_w0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic key(input bit p, input int c);
    step(1'b1, p, c, 1'b0, 1'b0);
  endtask

  task automatic adopt();
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    int k = 0;
    while (!settled() && k < 6 * TIMEOUT) begin
      idle(1);
      k++;
    end
    idle(2);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation in cycle and ids.
  exp_t e;
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse cycle %0d: got no pulse expected ids %0d/%0d at cycle %0d",
               cyc, exp_q[0].a, exp_q[0].b, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (new_f_out !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_pulse cycle %0d: got new_f_out=%b ids %0d/%0d expected no pulse",
                 cyc, new_f_out, freq_id1, freq_id2);
      end else begin
        e = exp_q.pop_front();
        if (freq_id1 !== e.a || freq_id2 !== e.b) begin
          errors++;
          $display("FAIL pulse_ids cycle %0d: got %0d/%0d expected %0d/%0d",
                   cyc, freq_id1, freq_id2, e.a, e.b);
        end else begin
          $display("pulse cycle %0d ids %0d/%0d ok", cyc, freq_id1, freq_id2);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kc;
    int r;
    int codes[8] = '{3, 5, 7, 9, 12, 24, 25, 0};

    repeat (3) step(1'b0, 1'b0, 0, 1'b0, 1'b1);

    key(1'b1, 5); idle(2); adopt(); drain();
    key(1'b0, 5); idle(2); adopt(); drain();
    key(1'b1, 3); idle(2); adopt(); drain();
    key(1'b1, 7); idle(2); adopt(); drain();
    key(1'b1, 9); idle(2); adopt(); drain();
    key(1'b0, 7); idle(2); adopt(); drain();

    // Empty the set, then change it twice while the 31/31 send is never adopted.
    key(1'b0, 9); idle(2);
    key(1'b1, 4); key(1'b1, 8);
    drain();
    key(1'b0, 4); key(1'b0, 8); drain();

    key(1'b1, 25); key(1'b0, 12); idle(5);
    key(1'b1, 5); key(1'b1, 5); idle(3); adopt(); drain();

    key(1'b1, 6); idle(3); key(1'b1, 10);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(5);

    key(1'b1, 6); idle(3); key(1'b0, 6); key(1'b1, 6); adopt(); idle(5); drain();

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      kc = (r < 8) ? codes[r] : int'($urandom_range(0, 31));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, kc,
           $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
    end
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_freq_encoder.md
Name: key_freq_encoder

Overview:
- Producer side of the frequency-id interface consumed by the physics block.
- Turns key press/release events (note codes 0-24) into a two-slot "held notes" set and drives freq_id1/freq_id2.
- Issues a single-cycle new-frequency pulse only when the set changes and the physics block has adopted the previous set, so the physics block never sees a new pulse mid-calculation.
- Sits between the keyboard decoder and the physics block, 65 MHz pixel clock domain.

Parameters:
- NO_FREQ, 31, freq id meaning "no frequency in this channel".
- MAX_ID, 24, highest valid note code; codes above are ignored.
- TIMEOUT, 2000000, cycles to wait in WAIT before giving up on adoption (~30 ms at 65 MHz); counter is 21 bits.

Ports:
- clock  in  1  65 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: key event present.
- key_press  in  1  qualifies key_valid: 1 = press, 0 = release.
- key_code  in  5  note code of the event, 0..24 valid.
- curr_w0  in  1  physics block's active-bank flag; a toggle means the last sent set was adopted.
- freq_id1  out  5  first frequency id to physics; NO_FREQ if none.
- freq_id2  out  5  second frequency id to physics; NO_FREQ if none.
- new_f_out  out  1  one-cycle pulse, connects to physics new_f_in.
- busy  out  1  high while in SEND or WAIT.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset values: slot1 = slot2 = NO_FREQ, freq_id1 = freq_id2 = NO_FREQ, new_f_out = 0, busy = 0, state IDLE, timer 0. Reset mid-WAIT returns to IDLE and does not emit a pulse.

Slot update (every cycle with key_valid, in any state; results register at the next edge):
- Ignore the event if key_code > MAX_ID.
- Press, code already in a slot: no change.
- Press, slot1 empty: slot1 <= code.
- Press, slot1 full and slot2 empty: slot2 <= code.
- Press, both full: slot1 <= slot2, slot2 <= code (oldest note evicted).
- Release matching slot1: slot1 <= slot2, slot2 <= NO_FREQ.
- Release matching slot2: slot2 <= NO_FREQ.
- Release with no matching slot: no change.
- Invariant: slot2 != NO_FREQ implies slot1 != NO_FREQ.

FSM (IDLE, SEND, WAIT):
- IDLE: if {slot1, slot2} != {freq_id1, freq_id2}, go to SEND. Otherwise stay.
- SEND (1 cycle):
  - freq_id1 <= slot1, freq_id2 <= slot2, new_f_out <= 1.
  - Latch curr_w0 into sent_bank and clear the timer.
  - Go to WAIT.
  - The freq_id outputs change on the same edge that raises new_f_out.
- WAIT:
  - new_f_out <= 0; timer increments each cycle.
  - Exit to IDLE when curr_w0 != sent_bank, or when timer == TIMEOUT-1.
  - freq_id outputs are held constant for the whole of WAIT.
- Latency: a key_valid at edge t updates the slots at t+1; with the FSM in IDLE, new_f_out and the new ids are visible after edge t+2.
- Coalescing: changes made during SEND or WAIT only update the slots. At return to IDLE the latest set is compared and sent once. Intermediate sets are never sent.
- No-op change: a press followed by its release while in WAIT leaves the slots equal to the sent set, so no pulse is emitted.
- new_f_out is never high on two consecutive cycles. At most one pulse per adoption or timeout.
- busy = (state != IDLE).

Test Plan:
- After reset, press code 5 -> two cycles later new_f_out pulses once, freq_id1=5, freq_id2=31, busy=1; toggle curr_w0 -> IDLE next cycle, busy=0.
- Press 3, adopt, press 7, adopt -> second pulse carries 3/7. Press 9 -> pulse carries 7/9 (oldest evicted). Release 7 -> pulse carries 9/31.
- During WAIT press 4 then 8 (slots empty beforehand), never toggle curr_w0 -> exactly TIMEOUT cycles after SEND FSM returns to IDLE, then one pulse carries 4/8; freq_id outputs unchanged throughout WAIT.
- Press code 25 and release of an unheld code 12 -> no slot change, no pulse. Press 5 twice -> a single pulse only.
- Assert reset during WAIT with pending changes -> next cycle outputs are 31/31, new_f_out=0, busy=0; no pulse afterwards until a new key event.
- Hold 6, adopt, then during WAIT release 6 and re-press 6 -> no further pulse after returning to IDLE.
